dm_responder: RTL
=================

# dm_responder

Data-memory responder at the far end of the pipeline's memory-stage interface. The memory stage acts as initiator and issues load/store requests over a valid/ready channel. This block accepts them, inserts a configurable number of wait states, and performs the 3072-word array access. It then returns read data and status over a valid/ready response channel. It also owns zero-initialisation of the array after reset.

## Interface
- WAIT_CYCLES, 1, wait states between request acceptance and response (0..15)
- DM_WORDS, 3072, array depth in 32-bit words (byte range 0x0000..0x2FFF)
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_be  input  4  byte-lane enables for stores; lane i = bits [8i+7:8i]
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_pc  input  32  PC of the issuing instruction (trace only)
- resp_valid  output  1  response present
- resp_ready  input  1  initiator accepts response
- resp_rdata  output  32  load data (full word); 0 for stores/errors
- resp_err  output  1  address out of range or misaligned

## Operation
- FSM states: INIT, IDLE, WAIT, RESP.
- INIT: entered on reset. A 12-bit clear pointer writes 0 to words 0..DM_WORDS-1, one per cycle. req_ready=0. After the last word is written, go to IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/be/addr/wdata/pc. Load the wait counter with WAIT_CYCLES. Go to WAIT, or go directly to RESP if WAIT_CYCLES=0.
- WAIT: req_ready=0. The counter decrements each cycle. On the edge where the counter is 1, perform the access and go to RESP.
- Access: error if addr>=4*DM_WORDS or addr[1:0]!=0. On error, the array is unchanged, resp_rdata=0 and resp_err=1.
- Store: merge only the enabled bytes into word addr[13:2]. be=0 is a legal no-op store. resp_rdata=0.
- Load: resp_rdata = word addr[13:2]. req_be is ignored.
- RESP: resp_valid=1 and the response fields are held stable until resp_valid&&resp_ready, then go to IDLE. req_ready=0 in RESP, so there is no overlap and only one transaction is ever outstanding.
- A request arriving during INIT/WAIT/RESP is not accepted. The initiator must hold it.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, state=INIT, clear pointer=0, wait counter=0.
- Init duration: DM_WORDS cycles after reset deasserts. req_ready rises after edge DM_WORDS.
- Acceptance at edge N: resp_valid is high after edge N+WAIT_CYCLES (WAIT_CYCLES=0 → after edge N). Minimum of one cycle in RESP.
- Back-to-back throughput: one transaction per WAIT_CYCLES+2 cycles when resp_ready is held at 1.
- Array update occurs on the same edge that enters RESP. A load issued after a store's response observes the new data.
- Reset asserted mid-transaction: all state is discarded immediately, no response is produced, and INIT restarts and re-clears the whole array.
- Outputs are registered. There is no combinational path from req_* or resp_ready to any output.

## Configuration
- DM_TRACE_EN defined: on every successful store access, simulation prints "<time>@<req_pc hex>: *<req_addr hex> <= <merged word hex>". Nothing is printed on errors.
- DM_TRACE_EN undefined: no print statements; behaviour is otherwise identical.

## Structure
- Package dm_pkg: DM_WORDS, DM_ADDR_LIMIT (0x3000), the state enum {INIT, IDLE, WAIT, RESP}, and the word-index width (12).
- Sub-module dm_ram: a single-port DM_WORDS×32 array with byte-enable write and synchronous write / combinational read. The FSM and handshake stay in dm_responder.

## Test plan
- Reset, then wait: req_ready stays 0 for exactly 3072 cycles, then rises. A load from 0x2FFC returns 0 with resp_err=0.
- Store 0x1234ABCD to 0x0010 with be=4'hF, then load 0x0010 → resp_rdata=0x1234ABCD. With WAIT_CYCLES=1, resp_valid rises 1 cycle after each acceptance.
- Store 0x000000EE to 0x0010 with be=4'h1, then load → 0x1234ABEE. Store with be=0 → word unchanged.
- Load 0x3000 → resp_err=1, rdata=0. Store to 0x0012 → resp_err=1 and the array is unchanged on readback.
- Hold resp_ready=0 for 5 cycles: resp_valid, rdata and err stay stable and req_ready stays 0. The response completes on the cycle resp_ready=1, then IDLE.
- Assert reset during WAIT after a store request: no response is produced, INIT reruns, and a load of that address returns 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared constants, FSM state type and byte-merge helper for the data-memory responder.
package dm_pkg;

    localparam int          DM_WORDS      = 3072;
    localparam logic [31:0] DM_ADDR_LIMIT = 32'h0000_3000;
    localparam int          DM_IDX_W      = 12;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } dm_state_e;

    // Word that results from writing the enabled lanes of i_new over i_old.
    function automatic logic [31:0] dm_merge(input logic [31:0] i_old,
                                             input logic [31:0] i_new,
                                             input logic [3:0]  i_be);
        logic [31:0] w_out;
        w_out = i_old;
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                w_out[8*b +: 8] = i_new[8*b +: 8];
            end
        end
        return w_out;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port word array: synchronous byte-enable write, combinational read.
module dm_ram #(
    parameter int DM_WORDS = dm_pkg::DM_WORDS
) (
    input  logic                        clk,
    input  logic                        i_we,
    input  logic [3:0]                  i_be,
    input  logic [dm_pkg::DM_IDX_W-1:0] i_idx,
    input  logic [31:0]                 i_wdata,
    output logic [31:0]                 o_rdata
);
    import dm_pkg::*;

    logic [31:0] r_mem [DM_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: clears the array after reset, then serves one load/store at a time
// with WAIT_CYCLES wait states. Optional store trace is enabled by defining DM_TRACE_EN.
module dm_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int DM_WORDS    = dm_pkg::DM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    import dm_pkg::*;

    localparam logic [3:0]          LP_WAIT  = 4'(WAIT_CYCLES);
    localparam logic [31:0]         LP_LIMIT = 32'(4 * DM_WORDS);
    localparam logic [DM_IDX_W-1:0] LP_LAST  = DM_IDX_W'(DM_WORDS - 1);

    dm_state_e           r_state;
    logic [DM_IDX_W-1:0] r_clr_ptr;
    logic [3:0]          r_cnt;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;

    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic                w_accept;
    logic                w_live;
    logic                w_acc_we;
    logic [3:0]          w_acc_be;
    logic [31:0]         w_acc_addr;
    logic [31:0]         w_acc_wdata;
    logic                w_acc_err;
    logic                w_do_access;
    logic                w_ram_we;
    logic [3:0]          w_ram_be;
    logic [DM_IDX_W-1:0] w_ram_idx;
    logic [31:0]         w_ram_wdata;
    logic [31:0]         w_ram_rdata;
    logic [31:0]         w_resp_rdata;

    assign w_accept = (r_state == ST_IDLE) && r_req_ready && req_valid;

    // With zero wait states the access happens on the accept edge, straight from the request.
    assign w_live      = (r_state == ST_IDLE);
    assign w_acc_we    = w_live ? req_we    : r_we;
    assign w_acc_be    = w_live ? req_be    : r_be;
    assign w_acc_addr  = w_live ? req_addr  : r_addr;
    assign w_acc_wdata = w_live ? req_wdata : r_wdata;
    assign w_acc_err   = (w_acc_addr >= LP_LIMIT) || (w_acc_addr[1:0] != 2'b00);

    assign w_do_access = (w_accept && (LP_WAIT == 4'd0)) ||
                         ((r_state == ST_WAIT) && (r_cnt == 4'd1));

    assign w_ram_we    = (r_state == ST_INIT) || (w_do_access && w_acc_we && !w_acc_err);
    assign w_ram_be    = (r_state == ST_INIT) ? 4'hF : w_acc_be;
    assign w_ram_idx   = (r_state == ST_INIT) ? r_clr_ptr : w_acc_addr[DM_IDX_W+1:2];
    assign w_ram_wdata = (r_state == ST_INIT) ? 32'd0 : w_acc_wdata;

    assign w_resp_rdata = (w_acc_err || w_acc_we) ? 32'd0 : w_ram_rdata;

    dm_ram #(
        .DM_WORDS (DM_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_idx   (w_ram_idx),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_be    <= req_be;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_INIT;
            r_clr_ptr    <= '0;
            r_cnt        <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == LP_LAST) begin
                        r_clr_ptr   <= '0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_cnt       <= LP_WAIT;
                        if (LP_WAIT == 4'd0) begin
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_resp_rdata;
                            r_resp_err   <= w_acc_err;
                            r_state      <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == 4'd1) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_resp_rdata;
                        r_resp_err   <= w_acc_err;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

`ifdef DM_TRACE_EN
    logic [31:0] r_pc;
    logic [31:0] w_acc_pc;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc <= req_pc;
        end
    end

    assign w_acc_pc = w_live ? req_pc : r_pc;

    always @(posedge clk) begin
        if (reset && w_do_access && w_acc_we && !w_acc_err) begin
            $display("%0t@%h: *%h <= %h", $time, w_acc_pc, w_acc_addr,
                     dm_merge(w_ram_rdata, w_acc_wdata, w_acc_be));
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^req_pc;
`endif

endmodule
